reg_dump_scanner: RTL

- Read-side sequencer for the register file's debug port: drives the 5-bit display index, samples the 32-bit display value, and streams (index, value) pairs out over a valid/ready handshake.
- Sits between the register file and the board display/UART dump logic; used for post-run register inspection without stalling the datapath.

---
 rtl/reg_dump_scanner_if.sv | 24 ++
 rtl/reg_dump_scanner.sv | 119 +++++++++++
 2 files changed

// File: rtl/reg_dump_scanner_if.sv
// Bundle between the register-dump scanner and its surroundings: start/abort
// control, the register file debug port, and the (index, value) output stream.
interface reg_dump_scanner_if;
    logic        start;
    logic        abort;
    logic [31:0] reg_return;
    logic        out_ready;
    logic [4:0]  show_index;
    logic        dump_valid;
    logic [4:0]  dump_index;
    logic [31:0] dump_data;
    logic        busy;
    logic        done;

    // master: the scanner itself; slave: the register file plus dump consumer
    modport master (
        input  start, abort, reg_return, out_ready,
        output show_index, dump_valid, dump_index, dump_data, busy, done
    );
    modport slave (
        output start, abort, reg_return, out_ready,
        input  show_index, dump_valid, dump_index, dump_data, busy, done
    );
endinterface

// File: rtl/reg_dump_scanner.sv
// Walks the register file debug port from START_IDX to END_IDX, letting each
// index settle before sampling, and streams (index, value) pairs downstream.
module reg_dump_scanner #(
    parameter int START_IDX     = 0,
    parameter int END_IDX       = 31,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_dump_scanner_if.master    bus
);

    localparam logic [4:0] START_L     = 5'(START_IDX);
    localparam logic [4:0] END_L       = 5'(END_IDX);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q;
    logic [4:0]  show_index_q;
    logic [3:0]  cnt_q;
    logic        dump_valid_q;
    logic [4:0]  dump_index_q;
    logic [31:0] dump_data_q;
    logic        busy_q;
    logic        done_q;

    logic [4:0]  idx_inc_d;
    logic [3:0]  cnt_inc_d;
    logic        transfer_d;

    always_comb begin
        idx_inc_d  = show_index_q + 5'd1;
        cnt_inc_d  = cnt_q + 4'd1;
        transfer_d = dump_valid_q & bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            show_index_q <= START_L;
            cnt_q        <= 4'd0;
            dump_valid_q <= 1'b0;
            dump_index_q <= 5'd0;
            dump_data_q  <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q      <= SETTLE;
                        show_index_q <= START_L;
                        cnt_q        <= 4'd0;
                        busy_q       <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        state_q      <= IDLE;
                        show_index_q <= START_L;
                        dump_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                        // Capture on the last settle cycle so the sample belongs to this edge
                        if (cnt_q == SETTLE_LAST) begin
                            dump_data_q  <= bus.reg_return;
                            dump_index_q <= show_index_q;
                            dump_valid_q <= 1'b1;
                            state_q      <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    // Abort wins over a transfer landing on the same edge
                    if (bus.abort) begin
                        state_q      <= IDLE;
                        show_index_q <= START_L;
                        dump_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (transfer_d) begin
                        dump_valid_q <= 1'b0;
                        if (show_index_q == END_L) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            show_index_q <= idx_inc_d;
                            cnt_q        <= 4'd0;
                            state_q      <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.show_index = show_index_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_index = dump_index_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
